// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: receiver FSM states, nominal line timing and a
// helper that turns a duration in microseconds into clock ticks.
package ws2812_pkg;

  typedef enum logic [2:0] {
    Idle    = 3'd0,
    High    = 3'd1,
    Low     = 3'd2,
    Stuck   = 3'd3,
    Forward = 3'd4
  } state_t;

  // Nominal line timing, also used by the ws2812 transmitter.
  localparam real T0hUs    = 0.40;
  localparam real T0lUs    = 0.85;
  localparam real T1hUs    = 0.85;
  localparam real T1lUs    = 0.40;
  localparam real TresetUs = 50.0;

  // Receiver decision points.
  localparam real GlitchUs    = 0.10;
  localparam real ThresholdUs = 0.625;
  localparam real MaxHighUs   = 1.50;
  localparam real ResetUs     = 50.0;

  localparam int WordW = 24;

  function automatic int ticks(input real mhz, input real us);
    return int'(mhz * us);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
module sync_2ff #(
  parameter logic RstVal = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Shift the asynchronous input through two flops.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RstVal;
      sync_q <= RstVal;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 receiver: measures high/low run lengths of the synchronized line,
// turns highs into bits MSB-first, emits 24-bit words and error/frame pulses.
// With ChainMode set it keeps the first word of a frame and forwards the rest.
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int   ClkFreqMhz  = 70,
  parameter int   GlitchTi    = ticks(real'(ClkFreqMhz), GlitchUs),
  parameter int   ThresholdTi = ticks(real'(ClkFreqMhz), ThresholdUs),
  parameter int   MaxHighTi   = ticks(real'(ClkFreqMhz), MaxHighUs),
  parameter int   ResetTi     = ticks(real'(ClkFreqMhz), ResetUs),
  parameter logic ChainMode   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ws_in,
  output logic [WordW-1:0] color,
  output logic             color_valid,
  output logic             frame_end,
  output logic             err_glitch,
  output logic             err_long,
  output logic             ws_out
);

  localparam int CntMax = (ResetTi > MaxHighTi) ? ResetTi : MaxHighTi;
  localparam int CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] CntOne    = CntW'(1);
  localparam logic [CntW-1:0] GlitchC   = CntW'(GlitchTi);
  localparam logic [CntW-1:0] ThreshC   = CntW'(ThresholdTi);
  localparam logic [CntW-1:0] MaxHighC  = CntW'(MaxHighTi);
  localparam logic [CntW-1:0] ResetC    = CntW'(ResetTi);
  localparam logic [4:0]      FirstBit  = 5'd23;

  logic ws_s;
  logic ws_q;

  state_t            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [4:0]        bit_idx_q, bit_idx_d;
  logic [WordW-1:0]  shift_q, shift_d;
  logic              seen_q, seen_d;
  logic [WordW-1:0]  color_q, color_d;
  logic              color_valid_q, color_valid_d;
  logic              frame_end_q, frame_end_d;
  logic              err_glitch_q, err_glitch_d;
  logic              err_long_q, err_long_d;
  logic              ws_out_q, ws_out_d;

  logic              rise;
  logic              bit_val;
  logic [CntW-1:0]   cnt_inc;
  logic [WordW-1:0]  new_word;

  sync_2ff #(.RstVal(1'b0)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ws_in),
    .q     (ws_s)
  );

  assign rise     = ws_s & ~ws_q;
  assign bit_val  = (cnt_q >= ThreshC);
  assign cnt_inc  = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + CntOne;
  assign new_word = {shift_q[WordW-2:0], bit_val};

  // Next-state, counter, word assembly and output pulse decisions.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    seen_d        = seen_q;
    color_d       = color_q;
    color_valid_d = 1'b0;
    frame_end_d   = 1'b0;
    err_glitch_d  = 1'b0;
    err_long_d    = 1'b0;
    ws_out_d      = 1'b0;

    unique case (state_q)
      Idle: begin
        cnt_d     = '0;
        bit_idx_d = FirstBit;
        seen_d    = 1'b0;
        if (rise) begin
          state_d = High;
          cnt_d   = CntOne;
        end
      end

      High: begin
        if (ws_s) begin
          cnt_d = cnt_inc;
          if (cnt_inc == MaxHighC) begin
            err_long_d = 1'b1;
            bit_idx_d  = FirstBit;
            shift_d    = '0;
            state_d    = Stuck;
          end
        end else if (cnt_q < GlitchC) begin
          // Too short to be a bit: drop the partial word and resync.
          err_glitch_d = 1'b1;
          bit_idx_d    = FirstBit;
          shift_d      = '0;
          cnt_d        = CntOne;
          state_d      = Low;
        end else begin
          shift_d = new_word;
          seen_d  = 1'b1;
          cnt_d   = CntOne;
          state_d = Low;
          if (bit_idx_q == 5'd0) begin
            color_d       = new_word;
            color_valid_d = 1'b1;
            bit_idx_d     = FirstBit;
            if (ChainMode) begin
              state_d = Forward;
            end
          end else begin
            bit_idx_d = bit_idx_q - 5'd1;
          end
        end
      end

      Low: begin
        if (ws_s) begin
          cnt_d   = CntOne;
          state_d = High;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == ResetC) begin
            frame_end_d = seen_q;
            cnt_d       = '0;
            bit_idx_d   = FirstBit;
            shift_d     = '0;
            state_d     = Idle;
          end
        end
      end

      Stuck: begin
        if (!ws_s) begin
          cnt_d     = CntOne;
          bit_idx_d = FirstBit;
          state_d   = Low;
        end
      end

      Forward: begin
        ws_out_d = ws_s;
        if (ws_s) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == ResetC) begin
            frame_end_d = seen_q;
            ws_out_d    = 1'b0;
            cnt_d       = '0;
            state_d     = Idle;
          end
        end
      end

      default: state_d = Idle;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ws_q          <= 1'b0;
      state_q       <= Idle;
      cnt_q         <= '0;
      bit_idx_q     <= FirstBit;
      shift_q       <= '0;
      seen_q        <= 1'b0;
      color_q       <= '0;
      color_valid_q <= 1'b0;
      frame_end_q   <= 1'b0;
      err_glitch_q  <= 1'b0;
      err_long_q    <= 1'b0;
      ws_out_q      <= 1'b0;
    end else begin
      ws_q          <= ws_s;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      seen_q        <= seen_d;
      color_q       <= color_d;
      color_valid_q <= color_valid_d;
      frame_end_q   <= frame_end_d;
      err_glitch_q  <= err_glitch_d;
      err_long_q    <= err_long_d;
      ws_out_q      <= ws_out_d;
    end
  end

  assign color       = color_q;
  assign color_valid = color_valid_q;
  assign frame_end   = frame_end_q;
  assign err_glitch  = err_glitch_q;
  assign err_long    = err_long_q;
  assign ws_out      = ws_out_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Self-checking bench for ws2812_rx: one decoder instance (ChainMode=0) and
// one pixel instance (ChainMode=1). Expected words, pulse counts and the
// forwarded line are derived from what the bench itself put on the wire.
`timescale 1ns/1ps
module tb_ws2812_rx;

  localparam int Mhz     = 70;
  localparam int GlitchC = int'(Mhz * 0.10);
  localparam int ThrC    = int'(Mhz * 0.625);
  localparam int MaxC    = int'(Mhz * 1.50);
  localparam int RstC    = int'(Mhz * 50.0);
  localparam int T0H = 28, T0L = 60, T1H = 60, T1L = 28;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ws_in0, ws_in1;
  logic [23:0] color0, color1;
  logic        valid0, valid1, fe0, fe1, eg0, eg1, el0, el1, ws_out0, ws_out1;

  ws2812_rx dut0 (
    .clk(clk), .rst_n(rst_n), .ws_in(ws_in0), .color(color0), .color_valid(valid0),
    .frame_end(fe0), .err_glitch(eg0), .err_long(el0), .ws_out(ws_out0)
  );

  ws2812_rx #(.ChainMode(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ws_in(ws_in1), .color(color1), .color_valid(valid1),
    .frame_end(fe1), .err_glitch(eg1), .err_long(el1), .ws_out(ws_out1)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Observations gathered by the monitor.
  logic [23:0] got0[$], got1[$];
  int fe0_n = 0, eg0_n = 0, el0_n = 0, fe1_n = 0, eg1_n = 0, el1_n = 0;
  int hold_viol = 0, wsout0_viol = 0;
  int cyc = 0, last_valid_cyc = 0, last_fall_cyc = 0;
  logic [23:0] prev_color0 = '0, prev_color1 = '0;
  logic hist[$];
  logic fwd_check = 1'b0;
  int fwd_mis = 0, fwd_hi = 0;

  // Bench-side expectations.
  logic [23:0] exp_q[$];
  int b_words0, b_fe0, b_eg0, b_el0;

  // Sample every output on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (valid0) begin got0.push_back(color0); last_valid_cyc = cyc; end
    if (valid1) got1.push_back(color1);
    if (fe0) fe0_n++;
    if (eg0) eg0_n++;
    if (el0) el0_n++;
    if (fe1) fe1_n++;
    if (eg1) eg1_n++;
    if (el1) el1_n++;
    if (rst_n && !valid0 && color0 !== prev_color0) hold_viol++;
    if (rst_n && !valid1 && color1 !== prev_color1) hold_viol++;
    prev_color0 = color0;
    prev_color1 = color1;
    if (ws_out0 !== 1'b0) wsout0_viol++;
    hist.push_back(ws_in1);
    if (hist.size() > 4) void'(hist.pop_front());
    if (fwd_check) begin
      if (ws_out1 !== hist[0]) fwd_mis++;
      if (ws_out1 === 1'b1) fwd_hi++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive a level for n cycles; inputs change 1 ns after the rising edge.
  task automatic hold(input int which, input logic v, input int n);
    if (which == 0) begin
      if (ws_in0 === 1'b1 && v === 1'b0) last_fall_cyc = cyc;
      ws_in0 = v;
    end else begin
      ws_in1 = v;
    end
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_nominal(input int which, input logic [23:0] w, input int bits);
    for (int i = 23; i > 23 - bits; i--) begin
      hold(which, 1'b1, w[i] ? T1H : T0H);
      hold(which, 1'b0, w[i] ? T1L : T0L);
    end
  endtask

  // Jittered widths, always well clear of the decision points.
  task automatic send_rand(input int which, input logic [23:0] w, input int bits);
    for (int i = 23; i > 23 - bits; i--) begin
      int hi;
      hi = w[i] ? int'($urandom_range(MaxC - 15, ThrC + 6))
                : int'($urandom_range(ThrC - 6, GlitchC + 3));
      hold(which, 1'b1, hi);
      hold(which, 1'b0, int'($urandom_range(80, 20)));
    end
  endtask

  task automatic snap();
    b_words0 = got0.size();
    b_fe0 = fe0_n; b_eg0 = eg0_n; b_el0 = el0_n;
    exp_q.delete();
  endtask

  task automatic check_run(input string tag, input int fe, input int gl, input int lg);
    check({tag, "_nwords"}, got0.size() - b_words0, exp_q.size());
    for (int i = 0; i < exp_q.size() && b_words0 + i < got0.size(); i++)
      check({tag, "_word"}, got0[b_words0 + i], exp_q[i]);
    check({tag, "_frame_end"}, fe0_n - b_fe0, fe);
    check({tag, "_err_glitch"}, eg0_n - b_eg0, gl);
    check({tag, "_err_long"}, el0_n - b_el0, lg);
  endtask

  initial begin
    logic [23:0] w, w2;
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] w;
    int pop;
    ws_in0 = 1'b0;
    ws_in1 = 1'b0;
    rst_n  = 1'b0;
    #23;
    check("rst_color0", color0, 0);
    check("rst_pulses0", {valid0, fe0, eg0, el0, ws_out0}, 0);
    check("rst_color1", color1, 0);
    check("rst_pulses1", {valid1, fe1, eg1, el1, ws_out1}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    hold(0, 1'b0, 5);

    // Repeating loopback-style words, then a frame gap.
    snap();
    repeat (3) begin send_nominal(0, 24'hA5C30F, 24); exp_q.push_back(24'hA5C30F); end
    hold(0, 1'b0, RstC + 100);
    check_run("t1", 1, 0, 0);

    // Hand-driven word, output latency from the last falling edge, frame end.
    snap();
    send_nominal(0, 24'h800001, 24);
    exp_q.push_back(24'h800001);
    check("t2_latency", last_valid_cyc - last_fall_cyc, 4);
    check("t2_color_held", color0, 24'h800001);
    hold(0, 1'b0, 3600);
    check_run("t2", 1, 0, 0);

    // Highs one below and exactly at the threshold.
    snap();
    w = 24'($urandom);
    w[23] = 1'b1; w[0] = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      hold(0, 1'b1, w[i] ? ThrC : ThrC - 1);
      hold(0, 1'b0, T0L);
    end
    exp_q.push_back(w);
    check_run("t3", 0, 0, 0);

    // Glitch mid-word, glitch on the 24th bit, and a high exactly at GlitchTi.
    snap();
    send_rand(0, 24'($urandom), 10);
    hold(0, 1'b1, 5);
    hold(0, 1'b0, 40);
    w = 24'($urandom);
    send_rand(0, w, 24);
    exp_q.push_back(w);
    send_rand(0, 24'($urandom), 23);
    hold(0, 1'b1, 4);
    hold(0, 1'b0, 40);
    w = 24'($urandom);
    for (int i = 23; i >= 0; i--) begin
      hold(0, 1'b1, w[i] ? T1H : GlitchC);
      hold(0, 1'b0, T0L);
    end
    exp_q.push_back(w);
    hold(0, 1'b0, RstC + 50);
    check_run("t4", 1, 2, 0);

    // Line stuck high, then recovery on the next word.
    snap();
    send_rand(0, 24'($urandom), 5);
    hold(0, 1'b1, 200);
    hold(0, 1'b0, 40);
    w = 24'($urandom);
    send_rand(0, w, 24);
    exp_q.push_back(w);
    hold(0, 1'b0, RstC + 50);
    check_run("t5", 1, 0, 1);

    // Random words with jittered timing in one frame.
    snap();
    repeat (3) begin w = 24'($urandom); send_rand(0, w, 24); exp_q.push_back(w); end
    hold(0, 1'b0, RstC + 50);
    check_run("t_rand", 1, 0, 0);
    check("ws_out_chain0_zero", wsout0_viol, 0);

    // Pixel mode: long idle gave no frame end; keep word 1, forward word 2.
    check("t6_idle_no_fe", fe1_n, 0);
    send_nominal(1, 24'h112233, 24);
    fwd_check = 1'b1;
    send_nominal(1, 24'h445566, 24);
    hold(1, 1'b0, 6);
    fwd_check = 1'b0;
    pop = $countones(24'h445566);
    check("t6_fwd_mismatch", fwd_mis, 0);
    check("t6_fwd_high_cycles", fwd_hi, pop * T1H + (24 - pop) * T0H);
    check("t6_nwords", got1.size(), 1);
    check("t6_color", color1, 24'h112233);
    hold(1, 1'b0, RstC + 50);
    check("t6_frame_end", fe1_n, 1);
    check("t6_ws_out_idle", ws_out1, 0);
    send_nominal(1, 24'h778899, 24);
    check("t6_nwords_frame2", got1.size(), 2);
    if (got1.size() == 2) check("t6_color_frame2", got1[1], 24'h778899);
    check("t6_errors", eg1_n + el1_n, 0);
    send_nominal(1, 24'hF0F0F0, 3);
    hold(1, 1'b1, 10);
    check("t6_fwd_high_before_rst", ws_out1, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_ws_out", ws_out1, 0);
    check("t6_rst_color1", color1, 0);
    check("t6_rst_color0", color0, 0);
    check("t6_rst_pulses", {valid1, fe1, eg1, el1}, 0);
    ws_in1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    check("color_hold_between_updates", hold_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
